// File: rtl/sevenseg_scan_driver_pkg.sv
// Shared definitions for the seven-segment scan driver: FSM states,
// display geometry and the active-low segment decode.
package sevenseg_pkg;

    localparam int unsigned DIGITS     = 8;
    localparam logic [6:0]  BLANK_CODE = 7'h7F;

    typedef enum logic {
        S_LOAD,
        S_SCAN
    } state_t;

    // Segment order {g,f,e,d,c,b,a}, a lit segment is 0
    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sevenseg_scan_driver_hex_to_7seg.sv
// Combinational nibble to active-low cathode pattern.
module hex_to_7seg
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg_decode(nibble);
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// 8-digit multiplexed common-anode display driver with per-frame input
// shadowing, anti-ghosting guard, leading-zero blanking and PWM brightness.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 1024,
    parameter int unsigned GUARD       = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] HEX_IN,
    input  logic [7:0]  DP_IN,
    input  logic        BLANK_LZ,
    input  logic [3:0]  BRIGHT,
    output logic [7:0]  ANODE,
    output logic [6:0]  CATHODE,
    output logic        DP_N,
    output logic        FRAME_TICK
);

    localparam int unsigned        PRESC_W = $clog2(REFRESH_DIV);
    localparam logic [PRESC_W-1:0] GUARD_P = PRESC_W'(GUARD);

    state_t             state, state_nxt;
    logic [PRESC_W-1:0] presc, presc_nxt;
    logic [2:0]         digit, digit_nxt;
    logic               load;
    logic               loaded;
    logic [31:0]        sh_hex;
    logic [7:0]         sh_dp;
    logic               sh_lz;

    logic [3:0]         nibble;
    logic [6:0]         seg;
    logic               blank;
    logic [3:0]         phase;
    logic               enable;
    logic [7:0]         anode_nxt;
    logic [6:0]         cathode_nxt;

    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        digit_nxt = digit;
        load      = 1'b0;
        case (state)
            S_LOAD: begin
                load      = 1'b1;
                presc_nxt = '0;
                digit_nxt = '0;
                state_nxt = S_SCAN;
            end
            S_SCAN: begin
                if (presc == '1) begin
                    presc_nxt = '0;
                    if (digit == 3'd7) begin
                        digit_nxt = '0;
                        load      = 1'b1;
                    end else begin
                        digit_nxt = digit + 3'd1;
                    end
                end else begin
                    presc_nxt = presc + PRESC_W'(1);
                end
            end
        endcase
    end

    // Upper PWM phase bits gate the anode; the guard keeps the first cycles
    // of each slot dark so the previous digit's segments never bleed over.
    always_comb begin
        nibble      = sh_hex[{digit, 2'b00} +: 4];
        blank       = sh_lz && (digit != 3'd0) && ((sh_hex >> {digit, 2'b00}) == 32'd0);
        phase       = presc[PRESC_W-1 -: 4];
        enable      = (presc >= GUARD_P) && (phase <= BRIGHT);
        anode_nxt   = enable ? ~(8'd1 << digit) : '1;
        cathode_nxt = blank ? BLANK_CODE : seg;
    end

    hex_to_7seg u_dec (
        .nibble (nibble),
        .seg    (seg)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= S_LOAD;
            presc      <= '0;
            digit      <= '0;
            sh_hex     <= '0;
            sh_dp      <= '0;
            sh_lz      <= 1'b0;
            loaded     <= 1'b0;
            FRAME_TICK <= 1'b0;
            ANODE      <= '1;
            CATHODE    <= BLANK_CODE;
            DP_N       <= 1'b1;
        end else begin
            state  <= state_nxt;
            presc  <= presc_nxt;
            digit  <= digit_nxt;
            loaded <= load;
            if (load) begin
                sh_hex <= HEX_IN;
                sh_dp  <= DP_IN;
                sh_lz  <= BLANK_LZ;
            end
            FRAME_TICK <= loaded;
            ANODE      <= anode_nxt;
            CATHODE    <= cathode_nxt;
            DP_N       <= ~sh_dp[digit];
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver with REFRESH_DIV=64, GUARD=2.
module tb_sevenseg_scan_driver;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] HEX_IN = 32'h0;
    logic [7:0]  DP_IN = 8'h0;
    logic        BLANK_LZ = 1'b0;
    logic [3:0]  BRIGHT = 4'd15;
    logic [7:0]  ANODE;
    logic [6:0]  CATHODE;
    logic        DP_N;
    logic        FRAME_TICK;

    int checks = 0;
    int errors = 0;
    // Scan index whose state the outputs currently show; -2 right after release
    int t = 0;

    sevenseg_scan_driver #(.REFRESH_DIV(64), .GUARD(2)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .HEX_IN     (HEX_IN),
        .DP_IN      (DP_IN),
        .BLANK_LZ   (BLANK_LZ),
        .BRIGHT     (BRIGHT),
        .ANODE      (ANODE),
        .CATHODE    (CATHODE),
        .DP_N       (DP_N),
        .FRAME_TICK (FRAME_TICK)
    );

    always #5 CLK = ~CLK;

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        t = -2;
    endtask

    task automatic adv_to(input int target);
        while (t < target) begin
            @(negedge CLK);
            t++;
        end
    endtask

    task automatic test_reset();
        HEX_IN = 32'h12345678;
        DP_IN  = 8'h01;
        do_reset();
        adv_to(198);
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if (ANODE !== 8'hFF) begin errors++; $display("FAIL reset_anode got %h want ff", ANODE); end
        checks++;
        if (CATHODE !== 7'h7F) begin errors++; $display("FAIL reset_cathode got %h want 7f", CATHODE); end
        checks++;
        if (DP_N !== 1'b1) begin errors++; $display("FAIL reset_dp got %b want 1", DP_N); end
        checks++;
        if (FRAME_TICK !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", FRAME_TICK); end
        @(negedge CLK);
        RESET = 1'b0;
        t = -2;
        adv_to(-1);
        checks++;
        if (FRAME_TICK !== 1'b0) begin errors++; $display("FAIL tick_edge1 got %b want 0", FRAME_TICK); end
        adv_to(0);
        checks++;
        if (FRAME_TICK !== 1'b1) begin errors++; $display("FAIL tick_edge2 got %b want 1", FRAME_TICK); end
        adv_to(1);
        checks++;
        if (FRAME_TICK !== 1'b0) begin errors++; $display("FAIL tick_edge3 got %b want 0", FRAME_TICK); end
    endtask

    task automatic test_digits();
        int n;
        HEX_IN = 32'h12345678;
        DP_IN  = 8'h01;
        do_reset();
        adv_to(0);
        checks++;
        if (FRAME_TICK !== 1'b1) begin errors++; $display("FAIL digits_tick got %b want 1", FRAME_TICK); end
        n = 0;
        do begin
            @(negedge CLK);
            t++;
            n++;
        end while (FRAME_TICK !== 1'b1 && n < 1000);
        checks++;
        if (n != 512) begin errors++; $display("FAIL frame_period got %0d want 512", n); end
        do_reset();
        adv_to(10);
        checks++;
        if ({ANODE, 1'b0, CATHODE, 7'b0, DP_N} !== {8'hFE, 1'b0, 7'h00, 7'b0, 1'b0})
            begin errors++; $display("FAIL slot0 got an=%h cat=%h dp=%b want fe 00 0", ANODE, CATHODE, DP_N); end
        adv_to(7 * 64 + 10);
        checks++;
        if ({ANODE, 1'b0, CATHODE, 7'b0, DP_N} !== {8'h7F, 1'b0, 7'h79, 7'b0, 1'b1})
            begin errors++; $display("FAIL slot7 got an=%h cat=%h dp=%b want 7f 79 1", ANODE, CATHODE, DP_N); end
    endtask

    task automatic test_shadow();
        HEX_IN = 32'h12345678;
        DP_IN  = 8'h00;
        do_reset();
        adv_to(3 * 64 + 10);
        HEX_IN = 32'hFFFFFFFF;
        adv_to(3 * 64 + 20);
        checks++;
        if (CATHODE !== 7'h12) begin errors++; $display("FAIL shadow_slot3 got %h want 12", CATHODE); end
        adv_to(511);
        checks++;
        if (CATHODE !== 7'h79 || FRAME_TICK !== 1'b0)
            begin errors++; $display("FAIL shadow_slot7 got cat=%h tick=%b want 79 0", CATHODE, FRAME_TICK); end
        adv_to(512);
        checks++;
        if (CATHODE !== 7'h0E || FRAME_TICK !== 1'b1)
            begin errors++; $display("FAIL shadow_new got cat=%h tick=%b want 0e 1", CATHODE, FRAME_TICK); end
    endtask

    task automatic test_back_to_back();
        HEX_IN = 32'h12345678;
        do_reset();
        adv_to(510);
        HEX_IN = 32'h87654321;
        adv_to(512 + 10);
        checks++;
        if (CATHODE !== 7'h79) begin errors++; $display("FAIL load_cycle_capture got %h want 79", CATHODE); end
        adv_to(1023);
        HEX_IN = 32'h0;
        adv_to(1024 + 10);
        checks++;
        if (CATHODE !== 7'h79) begin errors++; $display("FAIL after_load_ignored got %h want 79", CATHODE); end
        adv_to(1536 + 10);
        checks++;
        if (CATHODE !== 7'h40) begin errors++; $display("FAIL next_frame got %h want 40", CATHODE); end
    endtask

    task automatic test_lz();
        logic [6:0] exp_cat [8];
        int order [5];
        exp_cat = '{7'h40, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        order   = '{0, 1, 2, 5, 7};
        BLANK_LZ = 1'b1;
        HEX_IN   = 32'h000000A0;
        DP_IN    = 8'h80;
        do_reset();
        foreach (order[i]) begin
            adv_to(order[i] * 64 + 10);
            checks++;
            if (CATHODE !== exp_cat[order[i]])
                begin errors++; $display("FAIL lz_digit%0d got %h want %h", order[i], CATHODE, exp_cat[order[i]]); end
        end
        checks++;
        if (DP_N !== 1'b0) begin errors++; $display("FAIL lz_dp7 got %b want 0", DP_N); end
        HEX_IN = 32'h0;
        adv_to(512 + 10);
        checks++;
        if (CATHODE !== 7'h40) begin errors++; $display("FAIL lz_zero_d0 got %h want 40", CATHODE); end
        adv_to(512 + 64 + 10);
        checks++;
        if (CATHODE !== 7'h7F) begin errors++; $display("FAIL lz_zero_d1 got %h want 7f", CATHODE); end
        adv_to(512 + 3 * 64 + 10);
        checks++;
        if (CATHODE !== 7'h7F) begin errors++; $display("FAIL lz_zero_d3 got %h want 7f", CATHODE); end
        BLANK_LZ = 1'b0;
        DP_IN    = 8'h00;
    endtask

    task automatic test_brightness();
        logic [3:0] lvl [3];
        int         want [3];
        int         cnt, bad;
        lvl  = '{4'd0, 4'd15, 4'd7};
        want = '{2, 62, 30};
        HEX_IN = 32'h12345678;
        do_reset();
        foreach (lvl[i]) begin
            adv_to(64 * (i + 1) - 1);
            BRIGHT = lvl[i];
            cnt = 0;
            bad = 0;
            for (int p = 0; p < 64; p++) begin
                adv_to(64 * (i + 1) + p);
                if (ANODE !== 8'hFF) begin
                    cnt++;
                    if (ANODE !== ~(8'd1 << (i + 1))) bad++;
                end
            end
            checks++;
            if (cnt != want[i]) begin errors++; $display("FAIL bright%0d got %0d want %0d", lvl[i], cnt, want[i]); end
            checks++;
            if (bad != 0) begin errors++; $display("FAIL bright%0d_digit got %0d wrong want 0", lvl[i], bad); end
        end
        BRIGHT = 4'd15;
    endtask

    task automatic test_guard();
        int lead, multi;
        logic [7:0] an;
        HEX_IN = 32'h89ABCDEF;
        BRIGHT = 4'd15;
        do_reset();
        multi = 0;
        for (int s = 0; s < 8; s++) begin
            lead = 0;
            for (int p = 0; p < 64; p++) begin
                adv_to(s * 64 + p);
                an = ~ANODE;
                if ($countones(an) > 1) multi++;
                if (ANODE === 8'hFF && lead == p) lead++;
            end
            checks++;
            if (lead != 2) begin errors++; $display("FAIL guard_slot%0d got %0d want 2", s, lead); end
        end
        checks++;
        if (multi != 0) begin errors++; $display("FAIL two_anodes got %0d want 0", multi); end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_shadow();
        test_back_to_back();
        test_lz();
        test_brightness();
        test_guard();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
Downstream consumer of the wrapper's 32-bit SEVENSEGHEX value. Time-multiplexes the value onto an 8-digit common-anode seven-segment display, active-low.
- Latches the input once per frame into a shadow register, so a frame never shows a mix of old and new digits.
- Applies a blanking guard at each digit change to prevent ghosting.
- Supports optional leading-zero blanking and 16-level brightness PWM.
- Instantiated in TOP next to the wrapper, on the same divided clock.

Parameters:
REFRESH_DIV, 1024, CLK cycles per digit slot. Must be a power of two and >= 64. PRESC_W = log2(REFRESH_DIV).
GUARD, 2, cycles at the start of each slot during which all anodes are off. Must be < REFRESH_DIV/16.

Ports:
CLK  in  1  clock
RESET  in  1  reset
HEX_IN  in  32  value to display; nibble k drives digit k (digit 0 = rightmost)
DP_IN  in  8  decimal point enables, bit k = digit k, active-high
BLANK_LZ  in  1  leading-zero blanking enable
BRIGHT  in  4  brightness level, 0 = dimmest, 15 = full
ANODE  out  8  digit enables, active-low
CATHODE  out  7  segments {g,f,e,d,c,b,a}, active-low
DP_N  out  1  decimal point segment, active-low
FRAME_TICK  out  1  one-cycle pulse when the shadow register loads

Interface: reset RESET, asynchronous, active-high; clock CLK.

Behaviour:
Reset (asynchronous, may arrive at any time including mid-scan):
- ANODE=8'hFF, CATHODE=7'h7F, DP_N=1, FRAME_TICK=0.
- Prescaler=0, digit=0, shadow registers=0, state=S_LOAD.

FSM:
- S_LOAD, one cycle: copy HEX_IN, DP_IN, BLANK_LZ into the shadow registers; prescaler=0; digit=0; go to S_SCAN.
- S_SCAN: prescaler increments every cycle. When prescaler = REFRESH_DIV-1:
  - prescaler wraps to 0;
  - if digit = 7, digit wraps to 0 and the shadow registers reload from the inputs in that same cycle;
  - otherwise digit increments.
- RESET is the only way back to S_LOAD.

FRAME_TICK: a registered pulse, high exactly in the cycle after any shadow load (the S_LOAD load and every frame-wrap load).

Digit enable:
- Condition: prescaler >= GUARD AND phase <= BRIGHT, where phase = prescaler[PRESC_W-1:PRESC_W-4].
- When the condition holds, ANODE[digit]=0 and all other ANODE bits are 1. Otherwise ANODE=8'hFF.
- BRIGHT and the digit-enable condition are not shadowed; they take effect immediately.

Segments:
- CATHODE = decode(shadow nibble for the current digit).
- DP_N = ~shadow_dp[digit].
- Decode table, nibble 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).

Leading-zero blanking:
- Applies to digit k, k = 7..1, when shadow_lz=1 and shadow nibbles 7 down to k are all zero.
- A blanked digit drives CATHODE=7'h7F. Its DP is still driven from shadow_dp.
- Digit 0 is never blanked.

Latency and timing:
- All outputs are registered: they reflect the prescaler, digit and shadow state of the previous cycle.
- Frame period = 8*REFRESH_DIV cycles.
- Input changes between shadow loads are invisible on the outputs.
- If HEX_IN changes in the same cycle as a load, the value present in that cycle is the one captured.

Decomposition:
- Package sevenseg_pkg:
  - 16-entry segment-code constant or decode function;
  - FSM state encoding (S_LOAD, S_SCAN);
  - blank code 7'h7F;
  - digit count 8.
- Sub-module hex_to_7seg: purely combinational nibble to 7-bit cathode decode. The driver owns all registers.

Test Plan:
Bench uses REFRESH_DIV=64, GUARD=2, BRIGHT=15, BLANK_LZ=0 unless stated.
1. Reset: assert RESET mid-scan -> outputs go to ANODE=FF, CATHODE=7F, DP_N=1 without waiting for a clock edge. After release, FRAME_TICK pulses once, 2 cycles after the first edge.
2. HEX_IN=32'h12345678, DP_IN=8'h01 -> slot 0: ANODE=FE, CATHODE=00 ('8'), DP_N=0. Slot 7: ANODE=7F, CATHODE=79 ('1'), DP_N=1. Frame period is 512 cycles.
3. Change HEX_IN to 32'hFFFFFFFF during slot 3 -> slots 3..7 still show the old nibbles. The new value appears only after the next FRAME_TICK, with digit 0 CATHODE=0E.
4. BLANK_LZ=1, HEX_IN=32'h000000A0 -> digits 7..2 CATHODE=7F, digit 1 CATHODE=08, digit 0 CATHODE=40. With HEX_IN=0, only digit 0 is lit, showing 40.
5. Brightness, checked over each 64-cycle slot:
   - BRIGHT=0 -> anode active for exactly 2 cycles per slot (prescaler 2..3);
   - BRIGHT=15 -> active for 62 cycles;
   - BRIGHT=7 -> active for 30 cycles.
6. Guard: at every slot boundary, ANODE=FF for exactly GUARD cycles before the next digit lights. Two anodes are never low in the same cycle.
